// File: rtl/trans_seq.sv
// NxN matrix transpose sequencer: loads N rows over a valid/ready stream,
// then streams out the N columns as rows, one operation at a time.
module trans_seq #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_row,
  output logic           busy,
  output logic           done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_e;

  state_e                         state_q;
  logic [CW-1:0]                  cnt_q;
  logic [N-1:0][N-1:0][W-1:0]     buf_q;  // [row][col] element
  logic                           in_ready_q, out_valid_q, busy_q, done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_LOAD;
          cnt_q      <= '0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b1;
        end
        S_LOAD: if (in_valid && in_ready_q) begin
          for (int j = 0; j < N; j++)
            buf_q[cnt_q][j] <= in_row[W*(N-j)-1 -: W];
          if (cnt_q == LAST) begin
            state_q     <= S_EMIT;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_EMIT: if (out_valid_q && out_ready) begin
          if (cnt_q == LAST) begin
            state_q     <= S_DONE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Column cnt_q of the buffer; held stable by cnt_q during backpressure.
  always_comb begin
    out_row = '0;
    if (out_valid_q)
      for (int j = 0; j < N; j++)
        out_row[W*(N-j)-1 -: W] = buf_q[j][cnt_q];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_trans_seq.sv
// Directed bench for trans_seq (N=5, W=8) with hand-computed transposes.
module tb_trans_seq;
  localparam int N = 5;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst, start, in_valid, out_ready;
  logic           in_ready, out_valid, busy, done;
  logic [N*W-1:0] in_row, out_row;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [N*W-1:0] cur_in  [N];
  logic [N*W-1:0] cur_out [N];

  always #5 clk = ~clk;

  trans_seq #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_row(in_row), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"},  64'(in_ready),  64'd0);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".busy"},      64'(busy),      64'd0);
    chk({tag, ".done"},      64'(done),      64'd0);
    chk({tag, ".out_row"},   64'(out_row),   64'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start.in_ready", 64'(in_ready), 64'd1);
    chk("start.busy",     64'(busy),     64'd1);
  endtask

  // Feeds cur_in; optional in_valid stall of stall_n cycles before row stall_row.
  task automatic run_load(input int stall_row, input int stall_n, input bit st_pulse);
    for (int r = 0; r < N; r++) begin
      if (r == stall_row) begin
        for (int s = 0; s < stall_n; s++) begin
          start = st_pulse && (s == 1);
          tick();
          start = 1'b0;
          chk("lstall.in_ready",  64'(in_ready),  64'd1);
          chk("lstall.out_valid", 64'(out_valid), 64'd0);
        end
      end
      in_valid = 1'b1;
      in_row   = cur_in[r];
      tick();
      in_valid = 1'b0;
      in_row   = '0;
    end
  endtask

  // Checks cur_out; optional out_ready stall of stall_n cycles at row stall_row.
  // Returns in the DONE cycle.
  task automatic run_emit(input int stall_row, input int stall_n, input bit st_pulse);
    logic [N*W-1:0] held;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("emit%0d.valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("emit%0d.row", k),   64'(out_row),   64'(cur_out[k]));
      chk($sformatf("emit%0d.in_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("emit%0d.done", k),  64'(done),      64'd0);
      if (k == stall_row) begin
        held = out_row;
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          start = st_pulse && (s == 0);
          tick();
          start = 1'b0;
          chk("estall.valid", 64'(out_valid), 64'd1);
          chk("estall.row",   64'(out_row),   64'(held));
        end
      end
      out_ready = 1'b1;
      tick();
    end
    chk("done.pulse", 64'(done), 64'd1);
    chk("done.busy",  64'(busy), 64'd1);
    chk("done.valid", 64'(out_valid), 64'd0);
  endtask

  task automatic set_t1();
    cur_in[0] = 40'h01_03_02_05_00; cur_in[1] = 40'h00_01_00_00_00;
    cur_in[2] = 40'h00_00_01_00_00; cur_in[3] = 40'h00_00_00_01_00;
    cur_in[4] = 40'h00_00_00_00_01;
    cur_out[0] = 40'h01_00_00_00_00; cur_out[1] = 40'h03_01_00_00_00;
    cur_out[2] = 40'h02_00_01_00_00; cur_out[3] = 40'h05_00_00_01_00;
    cur_out[4] = 40'h00_00_00_00_01;
  endtask

  task automatic set_t2();
    cur_in[0] = 40'hFF_FD_FE_FB_00;
    for (int r = 1; r < N; r++) cur_in[r] = '0;
    cur_out[0] = 40'hFF_00_00_00_00; cur_out[1] = 40'hFD_00_00_00_00;
    cur_out[2] = 40'hFE_00_00_00_00; cur_out[3] = 40'hFB_00_00_00_00;
    cur_out[4] = 40'h00_00_00_00_00;
  endtask

  // Element (r,c) = 10r+c+1.
  task automatic set_t3();
    cur_in[0] = 40'h01_02_03_04_05; cur_in[1] = 40'h0B_0C_0D_0E_0F;
    cur_in[2] = 40'h15_16_17_18_19; cur_in[3] = 40'h1F_20_21_22_23;
    cur_in[4] = 40'h29_2A_2B_2C_2D;
    cur_out[0] = 40'h01_0B_15_1F_29; cur_out[1] = 40'h02_0C_16_20_2A;
    cur_out[2] = 40'h03_0D_17_21_2B; cur_out[3] = 40'h04_0E_18_22_2C;
    cur_out[4] = 40'h05_0F_19_23_2D;
  endtask

  initial begin
    int t0;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_row = '0;
    tick(); tick();
    chk_idle("reset");
    rst = 1'b1;
    tick();
    chk_idle("idle");

    // Positive data, no stalls, with done latency (start cycle counted as cycle 1)
    set_t1();
    t0 = cyc;
    do_start();
    run_load(-1, 0, 1'b0);
    run_emit(-1, 0, 1'b0);
    chk("t1.latency", 64'(cyc - t0 + 1), 64'd12);
    tick();
    chk_idle("t1.after");

    // Negative data
    set_t2();
    do_start();
    run_load(-1, 0, 1'b0);
    run_emit(-1, 0, 1'b0);
    tick();
    chk_idle("t2.after");

    // Backpressure on output row 2
    set_t3();
    do_start();
    run_load(-1, 0, 1'b0);
    run_emit(2, 3, 1'b0);
    tick();
    chk_idle("t3.after");

    // Input stall with extra starts during LOAD and EMIT; transpose of the transpose
    for (int r = 0; r < N; r++) begin
      logic [N*W-1:0] tmp;
      tmp = cur_in[r]; cur_in[r] = cur_out[r]; cur_out[r] = tmp;
    end
    do_start();
    run_load(2, 4, 1'b1);
    run_emit(1, 1, 1'b1);
    tick();
    chk_idle("t4.after");
    tick();
    chk("t4.single_done", 64'(done), 64'd0);
    chk("t4.stay_idle",   64'(busy), 64'd0);

    // Reset after 3 rows abandons the operation
    set_t3();
    do_start();
    for (int r = 0; r < 3; r++) begin
      in_valid = 1'b1; in_row = cur_in[r];
      tick();
    end
    in_valid = 1'b0; in_row = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_idle("t5.rst");
    tick(); tick();
    chk_idle("t5.no_done");

    set_t1();
    do_start();
    run_load(-1, 0, 1'b0);
    run_emit(-1, 0, 1'b0);

    // Back-to-back: start in the IDLE cycle right after DONE
    tick();
    chk_idle("t6.idle");
    set_t2();
    do_start();
    run_load(-1, 0, 1'b0);
    run_emit(-1, 0, 1'b0);
    tick();
    chk_idle("t6.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
